stage_de: RTL and testbench
===========================

STAGE_DE -- requirements
Module: stage_de

Interface
REQ-001 Parameter INST_W, 32, instruction width; decode field positions are fixed for 32.
REQ-002 Parameter DATA_W, 32, register and operand width.
REQ-003 Parameter REG_ADDR_W, 4, register index width; register file depth is 2^REG_ADDR_W.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 en  in  1  global enable; when low, no state changes.
REQ-007 flush  in  1  discard the instruction currently being decoded.
REQ-008 stall  in  1  downstream stall; hold all output registers.
REQ-009 in_flush  in  1  fetch-side bubble marker for in_inst.
REQ-010 in_inst  in  INST_W  fetched instruction.
REQ-011 wb_we  in  1  register write enable from writeback.
REQ-012 wb_rd  in  REG_ADDR_W  writeback register index.
REQ-013 wb_data  in  DATA_W  writeback data.
REQ-014 stall_req  out  1  combinational load-use hazard stall to fetch.
REQ-015 out_flush  out  1  bubble marker for the decoded slot.
REQ-016 out_alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
REQ-017 out_rd, out_rs1, out_rs2  out  REG_ADDR_W each  register indices.
REQ-018 out_rs1_val, out_rs2_val  out  DATA_W each  register operands.
REQ-019 out_imm  out  DATA_W  sign-extended imm14.
REQ-020 out_use_imm, out_reg_we, out_mem_rd, out_mem_wr, out_branch, out_jump, out_halt, out_illegal  out  1 each  control bits.

Function
REQ-021 Encoding: [31:26] opcode, [25:22] rd, [21:18] rs1, [17:14] rs2, [13:0] imm14.
REQ-022 Opcodes: 0x00 NOP; 0x01 ADD; 0x02 SUB; 0x03 AND; 0x04 OR; 0x05 XOR (all reg_we); 0x08 ADDI (reg_we, use_imm); 0x10 LOAD (reg_we, mem_rd, use_imm); 0x11 STORE (mem_wr, use_imm); 0x18 BEQ (branch, alu_op SUB); 0x19 JMP (jump); 0x3F HALT (halt).
REQ-023 Any other opcode: decode as NOP with out_illegal=1.
REQ-024 Register file: 2^REG_ADDR_W x DATA_W; register 0 reads 0 always; writes to 0 are ignored.
REQ-025 Write-through: when wb_we=1 and wb_rd equals a nonzero source index in the same cycle, the operand takes wb_data.
REQ-026 Register writes occur whenever wb_we=1 and en=1, regardless of stall, flush, or hazard.
REQ-027 Latency: one cycle; in_inst decoded in cycle N appears on the outputs after posedge N+1.
REQ-028 Hazard: stall_req=1 when all of the following hold: en=1; in_flush=0; the registered slot has out_flush=0 and out_mem_rd=1 with out_rd nonzero; and out_rd equals in_inst rs1 or rs2.
REQ-029 On a hazard with stall=0 and flush=0: load a bubble; fetch holds in_inst, so the instruction is re-presented and decoded next cycle.
REQ-030 Bubble: out_flush=1; all control bits 0; data and index outputs don't-care but driven 0.
REQ-031 Priority per posedge: rst > en=0 (hold) > flush (load bubble, stall_req forced 0) > stall (hold outputs) > hazard (bubble) > normal decode.
REQ-032 in_flush=1: load a bubble; raise no hazard.
REQ-033 stall_req is forced 0 while stall=1, so downstream stall alone freezes fetch.

Reset
REQ-034 While rst=1 at posedge: out_flush=1; all other outputs 0; all registers cleared to 0.
REQ-035 Reset mid-operation discards the in-flight decode; the first valid decode appears one cycle after rst falls.
REQ-036 stall_req=0 while rst=1.

Verification
REQ-037 Reset: rst=1 for 2 cycles -> out_flush=1, out_reg_we=0, and every register reads 0.
REQ-038 ADD x3,x1,x2 with x1=5 and x2=7 preloaded via wb -> next cycle out_alu_op=0, out_rs1_val=5, out_rs2_val=7, out_rd=3, out_reg_we=1, out_flush=0.
REQ-039 LOAD x4 followed by ADD x5,x4,x1 -> stall_req=1 for exactly 1 cycle, one bubble (out_flush=1), then the ADD decodes with out_rs1=4.
REQ-040 wb_we=1, wb_rd=2, wb_data=0xDEADBEEF in the same cycle an instruction reads x2 -> out_rs2_val=0xDEADBEEF; wb_rd=0 write -> x0 still reads 0.
REQ-041 ADDI with imm14=0x3FFF -> out_imm=0xFFFFFFFF, out_use_imm=1; opcode 0x2A -> out_illegal=1, out_reg_we=0.
REQ-042 stall=1 for 3 cycles while a decoded ADD is held -> outputs unchanged; flush=1 during a hazard -> bubble loaded, stall_req=0.

Source files
------------

// File: rtl/stage_de_if.sv
// Decode-stage bundle: fetch-side inputs, pipeline control, writeback port and decoded slot outputs.
// master drives the stage (pipeline/bench side); slave is the decode stage itself.
interface stage_de_if #(
   parameter int INST_W     = 32,
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 4
);
   logic                  en;
   logic                  flush;
   logic                  stall;
   logic                  in_flush;
   logic [INST_W-1:0]     in_inst;
   logic                  wb_we;
   logic [REG_ADDR_W-1:0] wb_rd;
   logic [DATA_W-1:0]     wb_data;

   logic                  stall_req;
   logic                  out_flush;
   logic [2:0]            out_alu_op;
   logic [REG_ADDR_W-1:0] out_rd;
   logic [REG_ADDR_W-1:0] out_rs1;
   logic [REG_ADDR_W-1:0] out_rs2;
   logic [DATA_W-1:0]     out_rs1_val;
   logic [DATA_W-1:0]     out_rs2_val;
   logic [DATA_W-1:0]     out_imm;
   logic                  out_use_imm;
   logic                  out_reg_we;
   logic                  out_mem_rd;
   logic                  out_mem_wr;
   logic                  out_branch;
   logic                  out_jump;
   logic                  out_halt;
   logic                  out_illegal;

   modport master (
      output en, flush, stall, in_flush, in_inst, wb_we, wb_rd, wb_data,
      input  stall_req, out_flush, out_alu_op, out_rd, out_rs1, out_rs2,
             out_rs1_val, out_rs2_val, out_imm, out_use_imm, out_reg_we,
             out_mem_rd, out_mem_wr, out_branch, out_jump, out_halt, out_illegal
   );

   modport slave (
      input  en, flush, stall, in_flush, in_inst, wb_we, wb_rd, wb_data,
      output stall_req, out_flush, out_alu_op, out_rd, out_rs1, out_rs2,
             out_rs1_val, out_rs2_val, out_imm, out_use_imm, out_reg_we,
             out_mem_rd, out_mem_wr, out_branch, out_jump, out_halt, out_illegal
   );
endinterface

// File: rtl/stage_de.sv
// Decode stage: register file with write-through, instruction decode into a registered slot,
// and load-use hazard detection that asks fetch to re-present the instruction.
module stage_de #(
   parameter int INST_W     = 32,
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 4
) (
   input logic      clk,
   input logic      rst,
   stage_de_if.slave bus
);
   localparam int DEPTH = 1 << REG_ADDR_W;

   typedef struct packed {
      logic                  flush;
      logic [2:0]            alu_op;
      logic [REG_ADDR_W-1:0] rd;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic [DATA_W-1:0]     rs1_val;
      logic [DATA_W-1:0]     rs2_val;
      logic [DATA_W-1:0]     imm;
      logic                  use_imm;
      logic                  reg_we;
      logic                  mem_rd;
      logic                  mem_wr;
      logic                  branch;
      logic                  jump;
      logic                  halt;
      logic                  illegal;
   } slot_t;

   logic [DATA_W-1:0]     regs [DEPTH];
   logic [5:0]            opcode;
   logic [REG_ADDR_W-1:0] rd_idx;
   logic [REG_ADDR_W-1:0] rs1_idx;
   logic [REG_ADDR_W-1:0] rs2_idx;
   logic [DATA_W-1:0]     rs1_val;
   logic [DATA_W-1:0]     rs2_val;
   logic                  hazard;
   slot_t                 bubble_slot;
   slot_t                 dec_slot;
   slot_t                 slot_reg;
   slot_t                 slot_next;

   assign opcode  = bus.in_inst[31:26];
   assign rd_idx  = bus.in_inst[25:22];
   assign rs1_idx = bus.in_inst[21:18];
   assign rs2_idx = bus.in_inst[17:14];

   // Register 0 is never written, so clearing it on reset keeps it zero; reads also force it.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (bus.en && bus.wb_we && bus.wb_rd != '0) begin
         regs[bus.wb_rd] <= bus.wb_data;
      end
   end

   assign rs1_val = (rs1_idx == '0) ? '0 :
                    (bus.wb_we && bus.wb_rd == rs1_idx) ? bus.wb_data : regs[rs1_idx];
   assign rs2_val = (rs2_idx == '0) ? '0 :
                    (bus.wb_we && bus.wb_rd == rs2_idx) ? bus.wb_data : regs[rs2_idx];

   always_comb begin
      bubble_slot       = '0;
      bubble_slot.flush = 1'b1;

      dec_slot         = '0;
      dec_slot.rd      = rd_idx;
      dec_slot.rs1     = rs1_idx;
      dec_slot.rs2     = rs2_idx;
      dec_slot.rs1_val = rs1_val;
      dec_slot.rs2_val = rs2_val;
      dec_slot.imm     = {{(DATA_W-14){bus.in_inst[13]}}, bus.in_inst[13:0]};
      case (opcode)
         6'h00: ;
         6'h01: dec_slot.reg_we = 1'b1;
         6'h02: begin dec_slot.reg_we = 1'b1; dec_slot.alu_op = 3'd1; end
         6'h03: begin dec_slot.reg_we = 1'b1; dec_slot.alu_op = 3'd2; end
         6'h04: begin dec_slot.reg_we = 1'b1; dec_slot.alu_op = 3'd3; end
         6'h05: begin dec_slot.reg_we = 1'b1; dec_slot.alu_op = 3'd4; end
         6'h08: begin dec_slot.reg_we = 1'b1; dec_slot.use_imm = 1'b1; end
         6'h10: begin
            dec_slot.reg_we  = 1'b1;
            dec_slot.mem_rd  = 1'b1;
            dec_slot.use_imm = 1'b1;
         end
         6'h11: begin dec_slot.mem_wr = 1'b1; dec_slot.use_imm = 1'b1; end
         6'h18: begin dec_slot.branch = 1'b1; dec_slot.alu_op = 3'd1; end
         6'h19: dec_slot.jump = 1'b1;
         6'h3F: dec_slot.halt = 1'b1;
         default: dec_slot.illegal = 1'b1;
      endcase
   end

   // Load-use: the load in the slot has not produced its data yet, so this instruction must wait.
   assign hazard = !bus.in_flush && !slot_reg.flush && slot_reg.mem_rd &&
                   (slot_reg.rd != '0) &&
                   (slot_reg.rd == rs1_idx || slot_reg.rd == rs2_idx);

   assign bus.stall_req = !rst && bus.en && !bus.flush && !bus.stall && hazard;

   always_comb begin
      slot_next = slot_reg;
      if (bus.flush) begin
         slot_next = bubble_slot;
      end else if (bus.stall) begin
         slot_next = slot_reg;
      end else if (hazard || bus.in_flush) begin
         slot_next = bubble_slot;
      end else begin
         slot_next = dec_slot;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_reg <= bubble_slot;
      end else if (bus.en) begin
         slot_reg <= slot_next;
      end
   end

   assign bus.out_flush   = slot_reg.flush;
   assign bus.out_alu_op  = slot_reg.alu_op;
   assign bus.out_rd      = slot_reg.rd;
   assign bus.out_rs1     = slot_reg.rs1;
   assign bus.out_rs2     = slot_reg.rs2;
   assign bus.out_rs1_val = slot_reg.rs1_val;
   assign bus.out_rs2_val = slot_reg.rs2_val;
   assign bus.out_imm     = slot_reg.imm;
   assign bus.out_use_imm = slot_reg.use_imm;
   assign bus.out_reg_we  = slot_reg.reg_we;
   assign bus.out_mem_rd  = slot_reg.mem_rd;
   assign bus.out_mem_wr  = slot_reg.mem_wr;
   assign bus.out_branch  = slot_reg.branch;
   assign bus.out_jump    = slot_reg.jump;
   assign bus.out_halt    = slot_reg.halt;
   assign bus.out_illegal = slot_reg.illegal;
endmodule

// File: tb/tb_stage_de.sv
// Bench for stage_de: directed scenarios followed by randomized traffic, all checked
// against a cycle-level behavioural model of the decode slot and register file.
module tb_stage_de;
   typedef struct packed {
      logic        flush;
      logic [2:0]  alu_op;
      logic [3:0]  rd;
      logic [3:0]  rs1;
      logic [3:0]  rs2;
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [31:0] imm;
      logic        use_imm;
      logic        reg_we;
      logic        mem_rd;
      logic        mem_wr;
      logic        branch;
      logic        jump;
      logic        halt;
      logic        illegal;
   } slot_t;

   logic clk;
   logic rst;
   stage_de_if #(.INST_W(32), .DATA_W(32), .REG_ADDR_W(4)) bus ();

   stage_de #(.INST_W(32), .DATA_W(32), .REG_ADDR_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   logic [31:0] m_regs [16];
   slot_t       m_slot;
   logic        exp_sr;
   logic        obs_sr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mk(input int op, input int rd, input int rs1,
                                      input int rs2, input int imm);
      logic [31:0] v;
      v = (32'(op & 63) << 26) | (32'(rd & 15) << 22) | (32'(rs1 & 15) << 18) |
          (32'(rs2 & 15) << 14) | 32'(imm & 16'h3FFF);
      return v;
   endfunction

   function automatic slot_t bubble();
      slot_t s;
      s       = '0;
      s.flush = 1'b1;
      return s;
   endfunction

   function automatic logic [31:0] model_read(input logic [3:0] idx);
      if (idx == 4'd0) return 32'd0;
      if (bus.wb_we && bus.wb_rd == idx) return bus.wb_data;
      return m_regs[idx];
   endfunction

   function automatic slot_t model_decode(input logic [31:0] inst);
      slot_t       s;
      int unsigned op;
      int unsigned imm14;
      s         = '0;
      op        = inst / (1 << 26);
      s.rd      = 4'((inst / (1 << 22)) % 16);
      s.rs1     = 4'((inst / (1 << 18)) % 16);
      s.rs2     = 4'((inst / (1 << 14)) % 16);
      s.rs1_val = model_read(s.rs1);
      s.rs2_val = model_read(s.rs2);
      imm14     = inst % 16384;
      s.imm     = (imm14 >= 8192) ? (32'(imm14) - 32'd16384) : 32'(imm14);
      case (op)
         0:  ;
         1:  s.reg_we = 1;
         2:  begin s.reg_we = 1; s.alu_op = 1; end
         3:  begin s.reg_we = 1; s.alu_op = 2; end
         4:  begin s.reg_we = 1; s.alu_op = 3; end
         5:  begin s.reg_we = 1; s.alu_op = 4; end
         8:  begin s.reg_we = 1; s.use_imm = 1; end
         16: begin s.reg_we = 1; s.mem_rd = 1; s.use_imm = 1; end
         17: begin s.mem_wr = 1; s.use_imm = 1; end
         24: begin s.branch = 1; s.alu_op = 1; end
         25: s.jump = 1;
         63: s.halt = 1;
         default: s.illegal = 1;
      endcase
      return s;
   endfunction

   function automatic logic model_hazard();
      logic [3:0] rs1;
      logic [3:0] rs2;
      rs1 = bus.in_inst[21:18];
      rs2 = bus.in_inst[17:14];
      return !bus.in_flush && !m_slot.flush && m_slot.mem_rd && m_slot.rd != 0 &&
             (m_slot.rd == rs1 || m_slot.rd == rs2);
   endfunction

   task automatic check_slot();
      chk("out_flush",   32'(bus.out_flush),   32'(m_slot.flush));
      chk("out_alu_op",  32'(bus.out_alu_op),  32'(m_slot.alu_op));
      chk("out_rd",      32'(bus.out_rd),      32'(m_slot.rd));
      chk("out_rs1",     32'(bus.out_rs1),     32'(m_slot.rs1));
      chk("out_rs2",     32'(bus.out_rs2),     32'(m_slot.rs2));
      chk("out_rs1_val", bus.out_rs1_val,      m_slot.rs1_val);
      chk("out_rs2_val", bus.out_rs2_val,      m_slot.rs2_val);
      chk("out_imm",     bus.out_imm,          m_slot.imm);
      chk("out_ctrl",
          {24'd0, bus.out_use_imm, bus.out_reg_we, bus.out_mem_rd, bus.out_mem_wr,
           bus.out_branch, bus.out_jump, bus.out_halt, bus.out_illegal},
          {24'd0, m_slot.use_imm, m_slot.reg_we, m_slot.mem_rd, m_slot.mem_wr,
           m_slot.branch, m_slot.jump, m_slot.halt, m_slot.illegal});
   endtask

   // One clock: check the combinational stall request, advance the model, check the slot.
   task automatic step();
      #1;
      exp_sr = !rst && bus.en && !bus.flush && !bus.stall && model_hazard();
      obs_sr = bus.stall_req;
      chk("stall_req", 32'(obs_sr), 32'(exp_sr));
      if (rst) begin
         m_slot = bubble();
         for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
      end else if (bus.en) begin
         if (bus.flush) m_slot = bubble();
         else if (bus.stall) m_slot = m_slot;
         else if (bus.in_flush || model_hazard()) m_slot = bubble();
         else m_slot = model_decode(bus.in_inst);
         if (bus.wb_we && bus.wb_rd != 0) m_regs[bus.wb_rd] = bus.wb_data;
      end
      @(posedge clk);
      #1;
      cyc++;
      $display("cyc %0d inst=%h rst=%b en=%b flush=%b stall=%b in_flush=%b req=%b out_flush=%b rd=%0d",
               cyc, bus.in_inst, rst, bus.en, bus.flush, bus.stall, bus.in_flush, obs_sr,
               bus.out_flush, bus.out_rd);
      check_slot();
   endtask

   task automatic idle_inputs();
      bus.en       = 1'b1;
      bus.flush    = 1'b0;
      bus.stall    = 1'b0;
      bus.in_flush = 1'b0;
      bus.in_inst  = 32'd0;
      bus.wb_we    = 1'b0;
      bus.wb_rd    = 4'd0;
      bus.wb_data  = 32'd0;
   endtask

   task automatic wb_write(input int rd, input logic [31:0] data);
      bus.wb_we   = 1'b1;
      bus.wb_rd   = 4'(rd);
      bus.wb_data = data;
      bus.in_inst = 32'd0;
      step();
      bus.wb_we = 1'b0;
   endtask

   logic [5:0] ops [12] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
                            6'h08, 6'h10, 6'h11, 6'h18, 6'h19, 6'h3F};

   initial begin
      m_slot = bubble();
      for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
      idle_inputs();
      rst = 1'b1;

      // Reset for two cycles
      step();
      step();
      chk("rst_flush", 32'(bus.out_flush), 32'd1);
      chk("rst_reg_we", 32'(bus.out_reg_we), 32'd0);
      rst = 1'b0;

      // Every register reads zero after reset
      for (int r = 0; r < 16; r += 2) begin
         bus.in_inst = mk(1, 1, r, r + 1, 0);
         step();
         chk("rst_reg_rs1", bus.out_rs1_val, 32'd0);
         chk("rst_reg_rs2", bus.out_rs2_val, 32'd0);
      end

      // ADD x3,x1,x2 after preloading x1=5, x2=7
      wb_write(1, 32'd5);
      wb_write(2, 32'd7);
      bus.in_inst = mk(1, 3, 1, 2, 0);
      step();
      chk("add_alu_op", 32'(bus.out_alu_op), 32'd0);
      chk("add_rs1_val", bus.out_rs1_val, 32'd5);
      chk("add_rs2_val", bus.out_rs2_val, 32'd7);
      chk("add_rd", 32'(bus.out_rd), 32'd3);
      chk("add_reg_we", 32'(bus.out_reg_we), 32'd1);
      chk("add_flush", 32'(bus.out_flush), 32'd0);

      // Load-use: one stall request, one bubble, then the ADD decodes
      bus.in_inst = mk(16, 4, 0, 0, 8);
      step();
      bus.in_inst = mk(1, 5, 4, 1, 0);
      step();
      chk("hz_req", 32'(obs_sr), 32'd1);
      chk("hz_bubble", 32'(bus.out_flush), 32'd1);
      step();
      chk("hz_req_clear", 32'(obs_sr), 32'd0);
      chk("hz_add_flush", 32'(bus.out_flush), 32'd0);
      chk("hz_add_rs1", 32'(bus.out_rs1), 32'd4);

      // Write-through and x0 write suppression
      bus.wb_we   = 1'b1;
      bus.wb_rd   = 4'd2;
      bus.wb_data = 32'hDEADBEEF;
      bus.in_inst = mk(1, 6, 1, 2, 0);
      step();
      chk("wt_rs2_val", bus.out_rs2_val, 32'hDEADBEEF);
      bus.wb_rd   = 4'd0;
      bus.wb_data = 32'hFFFF_FFFF;
      step();
      bus.wb_we   = 1'b0;
      bus.in_inst = mk(1, 6, 0, 2, 0);
      step();
      chk("x0_zero", bus.out_rs1_val, 32'd0);
      chk("x2_kept", bus.out_rs2_val, 32'hDEADBEEF);

      // Immediate sign extension and illegal opcode
      bus.in_inst = mk(8, 1, 1, 0, 16'h3FFF);
      step();
      chk("addi_imm", bus.out_imm, 32'hFFFF_FFFF);
      chk("addi_use_imm", 32'(bus.out_use_imm), 32'd1);
      bus.in_inst = mk(6'h2A, 3, 1, 2, 0);
      step();
      chk("ill_flag", 32'(bus.out_illegal), 32'd1);
      chk("ill_reg_we", 32'(bus.out_reg_we), 32'd0);

      // Downstream stall holds a decoded ADD for three cycles
      bus.in_inst = mk(1, 7, 1, 2, 0);
      step();
      bus.stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus.in_inst = mk(2, 9, 3, 3, k);
         step();
         chk("stall_rd", 32'(bus.out_rd), 32'd7);
         chk("stall_rs1_val", bus.out_rs1_val, 32'd5);
         chk("stall_req_low", 32'(obs_sr), 32'd0);
      end
      bus.stall = 1'b0;

      // Flush during a hazard loads a bubble without a stall request
      bus.in_inst = mk(16, 4, 0, 0, 0);
      step();
      bus.in_inst = mk(1, 5, 4, 1, 0);
      bus.flush   = 1'b1;
      step();
      chk("flush_hz_req", 32'(obs_sr), 32'd0);
      chk("flush_hz_bubble", 32'(bus.out_flush), 32'd1);
      bus.flush = 1'b0;

      // Randomized traffic; fetch holds the instruction while stall_req is asserted
      for (int n = 0; n < 800; n++) begin
         rst          = ($urandom_range(0, 99) == 0);
         bus.en       = ($urandom_range(0, 15) != 0);
         bus.flush    = ($urandom_range(0, 15) == 0);
         bus.stall    = ($urandom_range(0, 7) == 0);
         bus.in_flush = ($urandom_range(0, 9) == 0);
         bus.wb_we    = ($urandom_range(0, 1) == 1);
         bus.wb_rd    = 4'($urandom_range(0, 15));
         bus.wb_data  = $urandom;
         if (!exp_sr) begin
            if ($urandom_range(0, 7) == 0)
               bus.in_inst = mk(int'($urandom_range(0, 63)), int'($urandom_range(0, 3)),
                                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                                int'($urandom_range(0, 16383)));
            else
               bus.in_inst = mk(int'(ops[$urandom_range(0, 11)]), int'($urandom_range(0, 3)),
                                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                                int'($urandom_range(0, 16383)));
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
